// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the BCD countdown timer
//
// Purpose: state encoding, BCD digit type, digit maxima and the packed
//          HH:MM:SS patterns used by countdown_timer and bcd_down_digit.
// Ports:   none (package).
package timer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX9 = 4'd9;
   localparam bcd_t BCD_MAX5 = 4'd5;

   // Packed {hr1,hr0,min1,min0,sec1,sec0}
   localparam logic [23:0] TIME_ZERO    = 24'h00_00_00;
   localparam logic [23:0] TIME_ONE_SEC = 24'h00_00_01;

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD digit of a borrow-ripple down counter
//
// Purpose: holds one BCD digit; decrements when i_borrow_in is high,
//          wrapping 0 -> MAX and asserting o_borrow_out to the next digit.
// Ports:
//   i_clk         system clock
//   i_reset       asynchronous active-high reset (digit -> 0)
//   i_borrow_in   decrement request from the lower digit (or the tick)
//   i_load        load i_load_val on this edge (has priority)
//   i_load_val    value to load
//   o_digit       current digit value
//   o_borrow_out  digit is 0 while a decrement is requested
module bcd_down_digit
   import timer_pkg::*;
#(
   parameter bcd_t MAX = BCD_MAX9
)(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_borrow_in,
   input  logic i_load,
   input  bcd_t i_load_val,
   output bcd_t o_digit,
   output logic o_borrow_out
);

   bcd_t r_digit;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_digit <= '0;
      end else if (i_load) begin
         r_digit <= i_load_val;
      end else if (i_borrow_in) begin
         r_digit <= (r_digit == '0) ? MAX : r_digit - 4'd1;
      end
   end

   assign o_digit      = r_digit;
   assign o_borrow_out = i_borrow_in & (r_digit == '0);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - HH:MM:SS BCD countdown timer with alarm
//
// Purpose: loads a six-digit BCD preset, counts down once per tick while
//          running, and raises an alarm on reaching 00:00:00.
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to reload the last valid preset
//          after expiry and keep running (periodic timer).
// Ports:
//   i_clk, i_reset                  clock, asynchronous active-high reset
//   i_tick                          1 Hz one-cycle enable
//   i_start_resume, i_stop, i_load  one-cycle control pulses
//   i_set_hr1 .. i_set_sec0         BCD preset digits
//   o_hr1 .. o_sec0                 current BCD count
//   o_running, o_alarm              registered state flags (RUN, ALARM)
//   o_expired                       one-cycle pulse after expiry
//   o_load_err                      one-cycle pulse after a rejected load
module countdown_timer
   import timer_pkg::*;
#(
   parameter int MAX_HR      = 23,
   parameter int ALARM_TICKS = 10
)(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_tick,
   input  logic       i_start_resume,
   input  logic       i_stop,
   input  logic       i_load,
   input  logic [3:0] i_set_hr1,
   input  logic [3:0] i_set_hr0,
   input  logic [3:0] i_set_min1,
   input  logic [3:0] i_set_min0,
   input  logic [3:0] i_set_sec1,
   input  logic [3:0] i_set_sec0,
   output logic [3:0] o_hr1,
   output logic [3:0] o_hr0,
   output logic [3:0] o_min1,
   output logic [3:0] o_min0,
   output logic [3:0] o_sec1,
   output logic [3:0] o_sec0,
   output logic       o_running,
   output logic       o_alarm,
   output logic       o_expired,
   output logic       o_load_err
);

   state_t      r_state, w_next_state;
   logic        r_running, r_alarm, r_expired, r_load_err;
   logic [23:0] w_preset, w_count, w_load_val;
   logic [6:0]  w_borrow;
   logic [7:0]  w_hr_val;
   logic        w_load_valid, w_load_window, w_load_ok, w_load_bad;
   logic        w_start, w_start_nz, w_dec, w_expire, w_dig_load;
   logic        w_unused_hr_borrow;

   assign w_preset = {i_set_hr1, i_set_hr0, i_set_min1, i_set_min0, i_set_sec1, i_set_sec0};
   assign w_hr_val = 8'(i_set_hr1) * 8'd10 + 8'(i_set_hr0);

   assign w_load_valid = (i_set_hr1  <= BCD_MAX9) && (i_set_hr0  <= BCD_MAX9) &&
                         (i_set_min1 <= BCD_MAX5) && (i_set_min0 <= BCD_MAX9) &&
                         (i_set_sec1 <= BCD_MAX5) && (i_set_sec0 <= BCD_MAX9) &&
                         (w_hr_val <= 8'(MAX_HR));

   assign w_load_window = (r_state == IDLE) || (r_state == PAUSE);
   assign w_load_ok     = i_load & w_load_window & w_load_valid;
   assign w_load_bad    = i_load & w_load_window & ~w_load_valid;

   // stop beats start; a same-cycle load decides whether there is anything to run
   assign w_start    = i_start_resume & ~i_stop;
   assign w_start_nz = w_load_ok ? (w_preset != TIME_ZERO) : (w_count != TIME_ZERO);

   // RUN always holds a nonzero count, so the ripple can never pass 00:00:00
   assign w_dec    = (r_state == RUN) & i_tick & ~i_stop;
   assign w_expire = w_dec & (w_count == TIME_ONE_SEC);

   assign w_borrow[0]        = w_dec;
   assign w_unused_hr_borrow = w_borrow[6];

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [23:0] r_shadow;
   logic        w_reload;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_shadow <= TIME_ZERO;
      end else if (w_load_ok) begin
         r_shadow <= w_preset;
      end
   end

   // One cycle in ALARM, then back to RUN with the preset unless stopped
   assign w_reload   = (r_state == ALARM) & ~i_stop;
   assign w_dig_load = w_load_ok | w_reload;
   assign w_load_val = w_reload ? r_shadow : w_preset;
`else
   logic [7:0] r_alarm_cnt;

   // Counts ticks spent in ALARM; cleared whenever outside ALARM
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_alarm_cnt <= '0;
      end else if (r_state != ALARM) begin
         r_alarm_cnt <= '0;
      end else if (i_tick) begin
         r_alarm_cnt <= r_alarm_cnt + 8'd1;
      end
   end

   assign w_dig_load = w_load_ok;
   assign w_load_val = w_preset;
`endif

   // Digit 0 is sec0; minutes and seconds tens wrap at 5
   for (genvar g = 0; g < 6; g++) begin : g_digit
      localparam bcd_t DMAX = (g == 1 || g == 3) ? BCD_MAX5 : BCD_MAX9;
      bcd_down_digit #(.MAX(DMAX)) u_digit (
         .i_clk        (i_clk),
         .i_reset      (i_reset),
         .i_borrow_in  (w_borrow[g]),
         .i_load       (w_dig_load),
         .i_load_val   (w_load_val[g*4 +: 4]),
         .o_digit      (w_count[g*4 +: 4]),
         .o_borrow_out (w_borrow[g+1])
      );
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:  if (w_start && w_start_nz) w_next_state = RUN;
         RUN: begin
            if (i_stop)        w_next_state = PAUSE;
            else if (w_expire) w_next_state = ALARM;
         end
         PAUSE: if (w_start) w_next_state = w_start_nz ? RUN : IDLE;
         ALARM: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            w_next_state = i_stop ? IDLE : RUN;
`else
            if (i_stop) w_next_state = IDLE;
            else if (i_tick && (r_alarm_cnt == 8'(ALARM_TICKS - 1))) w_next_state = IDLE;
`endif
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_running  <= 1'b0;
         r_alarm    <= 1'b0;
         r_expired  <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_running  <= (w_next_state == RUN);
         r_alarm    <= (w_next_state == ALARM);
         r_expired  <= w_expire;
         r_load_err <= w_load_bad;
      end
   end

   assign {o_hr1, o_hr0, o_min1, o_min0, o_sec1, o_sec0} = w_count;
   assign o_running  = r_running;
   assign o_alarm    = r_alarm;
   assign o_expired  = r_expired;
   assign o_load_err = r_load_err;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
//
// Purpose: directed scenarios plus random control traffic, every cycle
//          compared against a seconds-based reference model.
// Ports:   none (top-level bench).
module tb_countdown_timer;

   localparam int MAX_HR      = 23;
   localparam int ALARM_TICKS = 10;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

   logic       clk = 1'b0;
   logic       reset, tick, start_resume, stop, load;
   logic [3:0] set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0;
   logic [3:0] hr1, hr0, min1, min0, sec1, sec0;
   logic       running, alarm, expired, load_err;
   logic [23:0] dut_digits;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: remaining time as plain seconds
   int m_secs, m_mode, m_acnt, m_shadow;
   bit m_exp, m_err;

   always #5 clk = ~clk;

   assign dut_digits = {hr1, hr0, min1, min0, sec1, sec0};

   countdown_timer #(.MAX_HR(MAX_HR), .ALARM_TICKS(ALARM_TICKS)) dut (
      .i_clk(clk), .i_reset(reset), .i_tick(tick),
      .i_start_resume(start_resume), .i_stop(stop), .i_load(load),
      .i_set_hr1(set_hr1), .i_set_hr0(set_hr0), .i_set_min1(set_min1),
      .i_set_min0(set_min0), .i_set_sec1(set_sec1), .i_set_sec0(set_sec0),
      .o_hr1(hr1), .o_hr0(hr0), .o_min1(min1), .o_min0(min0),
      .o_sec1(sec1), .o_sec0(sec0),
      .o_running(running), .o_alarm(alarm), .o_expired(expired), .o_load_err(load_err)
   );

   function automatic logic [23:0] to_bcd(input int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   function automatic void model_reset();
      m_secs = 0; m_mode = M_IDLE; m_acnt = 0; m_shadow = 0;
      m_exp = 1'b0; m_err = 1'b0;
   endfunction

   function automatic void model_step(input bit t, input bit st, input bit sp,
                                      input bit ld, input logic [23:0] pre);
      int  h, m, s;
      bit  valid, go;
      h = int'(pre[23:20]) * 10 + int'(pre[19:16]);
      m = int'(pre[15:12]) * 10 + int'(pre[11:8]);
      s = int'(pre[7:4]) * 10 + int'(pre[3:0]);
      valid = (pre[23:20] <= 9) && (pre[19:16] <= 9) && (pre[15:12] <= 5) &&
              (pre[11:8] <= 9) && (pre[7:4] <= 5) && (pre[3:0] <= 9) && (h <= MAX_HR);
      go    = st && !sp;
      m_exp = 1'b0;
      m_err = 1'b0;
      case (m_mode)
         M_IDLE, M_PAUSE: begin
            if (ld) begin
               if (valid) begin
                  m_secs   = h * 3600 + m * 60 + s;
                  m_shadow = m_secs;
               end else begin
                  m_err = 1'b1;
               end
            end
            if (go) begin
               if (m_secs > 0)            m_mode = M_RUN;
               else if (m_mode == M_PAUSE) m_mode = M_IDLE;
            end
         end
         M_RUN: begin
            if (sp) m_mode = M_PAUSE;
            else if (t) begin
               m_secs = m_secs - 1;
               if (m_secs == 0) begin
                  m_mode = M_ALARM; m_acnt = 0; m_exp = 1'b1;
               end
            end
         end
         default: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (sp) m_mode = M_IDLE;
            else begin
               m_secs = m_shadow; m_mode = M_RUN;
            end
`else
            if (sp) m_mode = M_IDLE;
            else if (t) begin
               m_acnt = m_acnt + 1;
               if (m_acnt == ALARM_TICKS) m_mode = M_IDLE;
            end
`endif
         end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".digits"},   dut_digits,       to_bcd(m_secs));
      chk({tag, ".running"},  24'(running),     24'(m_mode == M_RUN));
      chk({tag, ".alarm"},    24'(alarm),       24'(m_mode == M_ALARM));
      chk({tag, ".expired"},  24'(expired),     24'(m_exp));
      chk({tag, ".load_err"}, 24'(load_err),    24'(m_err));
   endtask

   // Drive one cycle of inputs, clock it, advance the model, compare
   task automatic cyc(input string tag, input bit t, input bit st, input bit sp,
                      input bit ld, input logic [23:0] pre);
      tick = t; start_resume = st; stop = sp; load = ld;
      {set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0} = pre;
      @(posedge clk);
      model_step(t, st, sp, ld, pre);
      #1;
      check_all(tag);
      tick = 1'b0; start_resume = 1'b0; stop = 1'b0; load = 1'b0;
   endtask

   initial begin
      logic [23:0] pre;
      bit t, st, sp, ld;

      reset = 1'b1; tick = 1'b0; start_resume = 1'b0; stop = 1'b0; load = 1'b0;
      {set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0} = '0;
      model_reset();
      #12;
      check_all("reset");
      reset = 1'b0;

      // Load 00:01:05 together with start, count through minute boundary
      cyc("ld_start", 0, 1, 0, 1, 24'h000105);
      repeat (5) cyc("tick", 1, 0, 0, 0, '0);
      chk("at_0100", dut_digits, 24'h000100);
      cyc("tick", 1, 0, 0, 0, '0);
      chk("at_0059", dut_digits, 24'h000059);
      repeat (59) cyc("tick", 1, 0, 0, 0, '0);
      chk("zero_digits", dut_digits, 24'h000000);
      chk("expired_pulse", 24'(expired), 24'd1);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
      cyc("alarm_hold", 0, 0, 0, 0, '0);
      chk("expired_once", 24'(expired), 24'd0);
      repeat (9) cyc("alarm_tick", 1, 0, 0, 0, '0);
      chk("alarm_9", 24'(alarm), 24'd1);
      cyc("alarm_tick", 1, 0, 0, 0, '0);
      chk("alarm_10", 24'(alarm), 24'd0);

      // Alarm silenced by stop after 3 ticks
      cyc("ld2", 0, 1, 0, 1, 24'h000002);
      repeat (2) cyc("tick2", 1, 0, 0, 0, '0);
      repeat (3) cyc("alarm3", 1, 0, 0, 0, '0);
      chk("alarm_before_stop", 24'(alarm), 24'd1);
      cyc("stop_alarm", 0, 0, 1, 0, '0);
      chk("alarm_after_stop", 24'(alarm), 24'd0);
`else
      cyc("stop_alarm", 0, 0, 1, 0, '0);
`endif

      // Load validity
      cyc("ld7", 0, 0, 0, 1, 24'h000007);
      cyc("ld_24h", 0, 0, 0, 1, 24'h240000);
      chk("err_24h", 24'(load_err), 24'd1);
      chk("keep_24h", dut_digits, 24'h000007);
      cyc("ld_60m", 0, 0, 0, 1, 24'h006000);
      chk("err_60m", 24'(load_err), 24'd1);
      cyc("ld_max", 0, 0, 0, 1, 24'h235959);
      chk("max_ok", dut_digits, 24'h235959);

      // stop+tick in RUN pauses without decrement
      cyc("ld10m", 0, 1, 0, 1, 24'h001000);
      cyc("stop_tick", 1, 0, 1, 0, '0);
      chk("pause_keep", dut_digits, 24'h001000);
      cyc("resume", 0, 1, 0, 0, '0);
      cyc("tick_r", 1, 0, 0, 0, '0);
      chk("at_0959", dut_digits, 24'h000959);
      cyc("ld_in_run", 0, 0, 0, 1, 24'h000500);
      chk("run_ld_ign", dut_digits, 24'h000959);
      cyc("pause", 0, 0, 1, 0, '0);
      cyc("ld0_start", 0, 1, 0, 1, 24'h000000);
      cyc("start_at0", 0, 1, 0, 0, '0);
      chk("idle_at0", 24'(running), 24'd0);

      // Asynchronous reset in the middle of a run
      cyc("ld_12345", 0, 1, 0, 1, 24'h012345);
      repeat (3) cyc("tick_pre_rst", 1, 0, 0, 0, '0);
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      reset = 1'b0;
      cyc("post_rst", 1, 0, 0, 0, '0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
      cyc("ld3", 0, 1, 0, 1, 24'h000003);
      for (int r = 0; r < 3; r++) begin
         repeat (3) cyc("tick3", 1, 0, 0, 0, '0);
         chk("reload_exp", 24'(expired), 24'd1);
         cyc("reload", 0, 0, 0, 0, '0);
         chk("reload_val", dut_digits, 24'h000003);
      end
      cyc("stop_r", 0, 0, 1, 0, '0);
`endif

      // Random control traffic against the model
      for (int i = 0; i < 1500; i++) begin
         t  = ($urandom_range(0, 1) == 0);
         st = ($urandom_range(0, 7) == 0);
         sp = ($urandom_range(0, 15) == 0);
         ld = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 5))
            0:       pre = 24'($urandom);
            1:       pre = to_bcd(int'($urandom_range(0, 86399)));
            default: pre = to_bcd(int'($urandom_range(0, 40)));
         endcase
         cyc("rand", t, st, sp, ld, pre);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- HH:MM:SS BCD countdown timer, the down-counting counterpart of the watch's up-counting mod-N digit chain.
- Loads a six-digit BCD preset, decrements once per 1 Hz tick enable, and raises an alarm on reaching 00:00:00.
- Sits beside the watch in the watch controller and shares its display digit format and its start/stop button semantics.

Parameters:
- MAX_HR, 23, largest loadable hour value; loads above it are rejected.
- ALARM_TICKS, 10, number of ticks the alarm output stays high after expiry; range 1..255.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- tick  input  1  one-cycle 1 Hz enable strobe.
- start_resume  input  1  one-cycle pulse; start or resume the countdown.
- stop  input  1  one-cycle pulse; pause the countdown or silence the alarm.
- load  input  1  one-cycle pulse; capture the preset digits.
- set_hr1, set_hr0, set_min1, set_min0, set_sec1, set_sec0  input  4 each  BCD preset.
- hr1, hr0, min1, min0, sec1, sec0  output  4 each  current BCD count.
- running  output  1  high in RUN.
- alarm  output  1  high in ALARM.
- expired  output  1  one-cycle pulse on expiry.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset: all digits 0, state IDLE, running/alarm/expired/load_err 0. Reset mid-RUN or mid-ALARM aborts immediately, with no expired pulse.
- States:
  - IDLE: load accepted. start_resume with a nonzero count goes to RUN. start_resume at zero is ignored.
  - RUN: each tick decrements by one second. stop goes to PAUSE. Load is ignored, with no load_err.
  - PAUSE: load accepted. start_resume goes to RUN if the count is nonzero, otherwise to IDLE.
  - ALARM: alarm=1. Returns to IDLE after ALARM_TICKS ticks, or on stop, whichever comes first. Load and start_resume are ignored.
- Load validity: every digit ≤9, sec1 ≤5, min1 ≤5, and hr1*10+hr0 ≤ MAX_HR.
  - A valid load updates all six digits on the next edge.
  - An invalid load leaves the digits unchanged and pulses load_err the following cycle.
- Decrement uses a borrow ripple:
  - sec0 9..0, wraps to 9 with borrow.
  - sec1 5..0, wraps to 5 with borrow.
  - min0 9..0, wraps to 9 with borrow.
  - min1 5..0, wraps to 5 with borrow.
  - hr0 9..0, wraps to 9 with borrow.
  - hr1 decrements on borrow.
  - The counter never wraps below 00:00:00.
- Expiry: a tick in RUN that produces 00:00:00 moves the state to ALARM on the same edge. expired is high for exactly that next cycle, and the alarm tick counter starts at 0.
- Latency: digits update on the edge where tick=1. Status outputs are registered, so they change on the same edge as the state.
- Simultaneous events:
  - stop and start_resume together: stop wins.
  - stop and tick in RUN: pause, no decrement.
  - load and start_resume in IDLE/PAUSE: load applied first, start evaluated against the new value. A zero load does not start.
  - tick without RUN: no effect.

Optional Feature:
- Macro COUNTDOWN_AUTO_RELOAD_EN.
- When defined:
  - The last valid preset is held in a shadow register.
  - On expiry, expired still pulses and the ALARM state is entered for one cycle only.
  - The preset is then reloaded and the state returns to RUN automatically, giving a periodic timer.
  - stop in ALARM goes to IDLE with the digits at zero.
- When undefined: no shadow register; behaviour as specified above.

Decomposition:
- Package timer_pkg:
  - state enum {IDLE, RUN, PAUSE, ALARM};
  - BCD digit typedef (4-bit);
  - constants for digit maxima (9, 5) and the 00:00:00 pattern.
- Sub-module bcd_down_digit:
  - one digit, parameter MAX;
  - inputs: borrow_in, load, load value;
  - outputs: digit, borrow_out (asserted when digit=0 and borrow_in).
  - Instantiated six times with MAX 9/5/9/5/9/9. hr1 is limited by the load check only.

Test Plan:
- Load 00:01:05, start, 5 ticks → 00:01:00. Next tick → 00:00:59. 59 more ticks → 00:00:00, expired pulse, alarm=1.
- Preset 00:00:02, run to ALARM with ALARM_TICKS=10 → alarm high for 10 ticks, then IDLE. Repeat and pulse stop after 3 ticks → IDLE immediately.
- Load 24:00:00 with MAX_HR=23, and separately 00:60:00 → load_err pulse, digits unchanged. Load 23:59:59 → accepted.
- In RUN at 00:10:00, stop and tick together → PAUSE, count still 00:10:00. start_resume → RUN, next tick → 00:09:59.
- Load in RUN → ignored, no load_err. start_resume in IDLE at 00:00:00 → stays IDLE.
- Assert reset mid-RUN at 01:23:45 → all digits 0, running 0, no expired. With COUNTDOWN_AUTO_RELOAD_EN and preset 00:00:03 → expired pulses every 3 ticks, count reloads to 00:00:03.
